// File: rtl/resource_demapper_ctrl.sv
// rtl/resource_demapper_ctrl.sv - ping-pong sample RAM sequencer between FFT output and symbol demapper (optional macro PILOT_SKIP_EN)
module resource_demapper_ctrl #(
    parameter int N_FFT         = 64,
    parameter int ADDR_W        = 6,
    parameter int PILOT_SPACING = 4,
    parameter int PILOT_OFFSET  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_FFT_Valid,
    input  logic [ADDR_W-1:0] i_sc_start,
    input  logic [ADDR_W:0]   i_sc_len,
    input  logic              i_out_ready,
    output logic              o_wr_en,
    output logic [ADDR_W:0]   o_wr_addr,
    output logic              o_rd_en,
    output logic [ADDR_W:0]   o_rd_addr,
    output logic              o_out_valid,
    output logic              o_sym_done,
    output logic              o_overflow
);

    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} r_state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_FFT - 1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   REM_ZERO = '0;

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic              wr_bank, rd_bank;
    logic [ADDR_W-1:0] wr_cnt, rd_idx;
    logic [ADDR_W:0]   rem;
    logic              bank_full, handover, is_pilot, skip, issue, accept;

    // The write strobe follows the FFT valid directly; it is forced low while reset is held.
    assign o_wr_en   = i_FFT_Valid & i_rst_n;
    assign o_wr_addr = {wr_bank, wr_cnt};
    assign bank_full = o_wr_en && (wr_cnt == LAST_IDX);
    // A full bank is handed to the reader only if the reader is already idle.
    assign handover  = bank_full && (r_state == R_IDLE);

`ifdef PILOT_SKIP_EN
    assign is_pilot = ((32'(rd_idx) % 32'(PILOT_SPACING)) == 32'(PILOT_OFFSET));
`else
    assign is_pilot = 1'b0;
`endif

    assign skip      = (rd_idx == '0) || is_pilot;
    assign accept    = o_out_valid && i_out_ready;
    // Issue a read only when the output register is free or being emptied this cycle.
    assign issue     = (r_state == R_READ) && !skip && (!o_out_valid || i_out_ready);
    assign o_rd_en   = issue;
    assign o_rd_addr = {rd_bank, rd_idx};

    // Write FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write FSM next state: leave idle on the first sample, return once the bank is full.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (o_wr_en)   w_next = W_FILL;
            W_FILL:  if (bank_full) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write counter and bank swap; an overflowed symbol keeps its bank so the next one overwrites it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (o_wr_en) wr_cnt <= bank_full ? '0 : wr_cnt + 1'b1;
            if (handover) begin
                rd_bank <= wr_bank;
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read FSM next state: read until the last sample is issued, then wait for its acceptance.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (handover && (i_sc_len != REM_ZERO)) r_next = R_READ;
            R_READ:  if (issue && (rem == REM_ONE))          r_next = R_DRAIN;
            R_DRAIN: if (accept)                             r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read index/remaining count; skipped indices advance the index without consuming the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_idx <= '0;
            rem    <= '0;
        end else if (handover) begin
            rd_idx <= i_sc_start;
            rem    <= i_sc_len;
        end else begin
            if ((r_state == R_READ) && (skip || issue)) rd_idx <= rd_idx + 1'b1;
            if (issue) rem <= rem - REM_ONE;
        end
    end

    // Output valid and status pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid <= 1'b0;
            o_sym_done  <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (issue)            o_out_valid <= 1'b1;
            else if (i_out_ready) o_out_valid <= 1'b0;
            o_sym_done <= (handover && (i_sc_len == REM_ZERO)) || ((r_state == R_DRAIN) && accept);
            o_overflow <= bank_full && (r_state != R_IDLE);
        end
    end

endmodule
